// File: rtl/mux_varredura.sv
// mux_varredura
// -------------
// N-channel, WIDTH-bit registered multiplexer with two operating modes:
//   - manual: the channel driving OUT follows SEL (one cycle of latency)
//   - scan:   the channel advances round-robin every DWELL clock cycles
// HOLD freezes all state (channel, dwell counter, output) and has priority
// over MODO. Reset has priority over everything and is asynchronous.
//
// Ports:
//   clock  in  1        system clock, rising edge
//   reset  in  1        asynchronous, active-high reset
//   D      in  N*WIDTH  flattened channel data, channel k = D[k*WIDTH +: WIDTH]
//   SEL    in  CW       channel index used in manual mode
//   MODO   in  1        0 = manual, 1 = scan
//   HOLD   in  1        1 = freeze all state
//   OUT    out WIDTH    registered data of the current channel
//                       (all ones while the channel index is invalid)
//   CANAL  out CW       registered index of the channel driving OUT
//   TROCA  out 1        one-cycle pulse in the cycle CANAL takes a new value
module mux_varredura #(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    parameter int DWELL = 1000,
    localparam int CW   = ($clog2(N) > 1) ? $clog2(N) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] D,
    input  logic [CW-1:0]      SEL,
    input  logic               MODO,
    input  logic               HOLD,
    output logic [WIDTH-1:0]   OUT,
    output logic [CW-1:0]      CANAL,
    output logic               TROCA
);

    localparam int              CNTW     = $clog2(DWELL) + 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);
    localparam logic [CW-1:0]   LAST_CH  = CW'(N - 1);
    localparam int              NSLOT    = 2 ** CW;

    // A channel index is only meaningful below N; with N not a power of two
    // the upper codes of SEL/CANAL are invalid.
    function automatic logic chan_valid(input logic [CW-1:0] ch);
        return (32'(ch) < 32'(N));
    endfunction

    logic [CW-1:0]    canal_r;
    logic [CNTW-1:0]  cnt_r;
    logic [WIDTH-1:0] out_r;
    logic             troca_r;

    logic [CW-1:0]    next_ch_s;
    logic [CNTW-1:0]  next_cnt_s;
    logic [WIDTH-1:0] ch_data_s [NSLOT];

    // Unpack D into one entry per index code. Codes without a channel read as
    // all ones, so selecting an invalid index yields the invalid-select value
    // without a separate mux stage.
    generate
        for (genvar k = 0; k < NSLOT; k++) begin : g_ch
            if (k < N) begin : g_valid
                assign ch_data_s[k] = D[k*WIDTH +: WIDTH];
            end else begin : g_invalid
                assign ch_data_s[k] = {WIDTH{1'b1}};
            end
        end
    endgenerate

    // Next channel / dwell counter selection: HOLD > manual > scan.
    always_comb begin
        next_ch_s  = canal_r;
        next_cnt_s = cnt_r;
        if (HOLD) begin
            next_ch_s  = canal_r;
            next_cnt_s = cnt_r;
        end else if (!MODO) begin
            next_ch_s  = SEL;
            next_cnt_s = {CNTW{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            next_cnt_s = {CNTW{1'b0}};
            if ((canal_r == LAST_CH) || !chan_valid(canal_r)) begin
                next_ch_s = {CW{1'b0}};
            end else begin
                next_ch_s = canal_r + CW'(1);
            end
        end else begin
            next_cnt_s = cnt_r + CNTW'(1);
            // An invalid channel left over from manual mode is abandoned at
            // once rather than waiting out a full dwell.
            if (chan_valid(canal_r)) begin
                next_ch_s = canal_r;
            end else begin
                next_ch_s = {CW{1'b0}};
            end
        end
    end

    // State and output registers; HOLD keeps everything except the strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            canal_r <= {CW{1'b0}};
            cnt_r   <= {CNTW{1'b0}};
            out_r   <= {WIDTH{1'b0}};
            troca_r <= 1'b0;
        end else if (HOLD) begin
            troca_r <= 1'b0;
        end else begin
            canal_r <= next_ch_s;
            cnt_r   <= next_cnt_s;
            out_r   <= ch_data_s[next_ch_s];
            troca_r <= (next_ch_s != canal_r);
        end
    end

    assign OUT   = out_r;
    assign CANAL = canal_r;
    assign TROCA = troca_r;

endmodule

// File: tb/tb_mux_varredura.sv
// Directed testbench for mux_varredura.
// Three instances: A (N=4, DWELL=3), B (N=3, DWELL=3, invalid index),
// C (N=4, DWELL=1, fast scan and mid-sweep reset). WIDTH=4 throughout.
module tb_mux_varredura;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Instance A
    logic        a_rst = 1'b0;
    logic [15:0] a_d   = 16'hDCBA;
    logic [1:0]  a_sel = 2'd0;
    logic        a_modo = 1'b0;
    logic        a_hold = 1'b0;
    logic [3:0]  a_out;
    logic [1:0]  a_canal;
    logic        a_troca;

    // Instance B
    logic        b_rst = 1'b0;
    logic [11:0] b_d   = 12'hCBA;
    logic [1:0]  b_sel = 2'd0;
    logic        b_modo = 1'b0;
    logic        b_hold = 1'b0;
    logic [3:0]  b_out;
    logic [1:0]  b_canal;
    logic        b_troca;

    // Instance C
    logic        c_rst = 1'b0;
    logic [15:0] c_d   = 16'h4321;
    logic [1:0]  c_sel = 2'd0;
    logic        c_modo = 1'b0;
    logic        c_hold = 1'b0;
    logic [3:0]  c_out;
    logic [1:0]  c_canal;
    logic        c_troca;

    mux_varredura #(.WIDTH(4), .N(4), .DWELL(3)) dut_a (
        .clock(clk), .reset(a_rst), .D(a_d), .SEL(a_sel), .MODO(a_modo),
        .HOLD(a_hold), .OUT(a_out), .CANAL(a_canal), .TROCA(a_troca)
    );

    mux_varredura #(.WIDTH(4), .N(3), .DWELL(3)) dut_b (
        .clock(clk), .reset(b_rst), .D(b_d), .SEL(b_sel), .MODO(b_modo),
        .HOLD(b_hold), .OUT(b_out), .CANAL(b_canal), .TROCA(b_troca)
    );

    mux_varredura #(.WIDTH(4), .N(4), .DWELL(1)) dut_c (
        .clock(clk), .reset(c_rst), .D(c_d), .SEL(c_sel), .MODO(c_modo),
        .HOLD(c_hold), .OUT(c_out), .CANAL(c_canal), .TROCA(c_troca)
    );

    // Manual stepping table (instance A, D = DCBA)
    localparam logic [1:0] MAN_SEL [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    localparam logic [3:0] MAN_OUT [4] = '{4'hB, 4'hC, 4'hD, 4'hA};

    // Scan from reset, DWELL=3: CANAL/OUT/TROCA after each of 12 edges
    localparam logic [1:0] SCAN_CH  [12] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
                                            2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    localparam logic [3:0] SCAN_OUT [12] = '{4'hA, 4'hA, 4'hB, 4'hB, 4'hB, 4'hC,
                                            4'hC, 4'hC, 4'hD, 4'hD, 4'hD, 4'hA};
    localparam logic       SCAN_TR  [12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                                            1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    // DWELL=1 sweep from channel 0 (D = 4321)
    localparam logic [1:0] FAST_CH  [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    localparam logic [3:0] FAST_OUT [6] = '{4'h2, 4'h3, 4'h4, 4'h1, 4'h2, 4'h3};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        a_rst = 1'b1;
        b_rst = 1'b1;
        c_rst = 1'b1;
        tick();
        vectors++;
        if (a_out !== 4'h0 || a_canal !== 2'd0 || a_troca !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_a: got out=%h canal=%0d troca=%b, want 0/0/0", a_out, a_canal, a_troca);
        end
        vectors++;
        if (b_out !== 4'h0 || b_canal !== 2'd0 || b_troca !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_b: got out=%h canal=%0d troca=%b, want 0/0/0", b_out, b_canal, b_troca);
        end
        vectors++;
        if (c_out !== 4'h0 || c_canal !== 2'd0 || c_troca !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_c: got out=%h canal=%0d troca=%b, want 0/0/0", c_out, c_canal, c_troca);
        end
        #2;
        a_rst = 1'b0;
        b_rst = 1'b0;
        c_rst = 1'b0;
        tick();
        vectors++;
        if (a_out !== 4'hA || a_canal !== 2'd0 || a_troca !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_a: got out=%h canal=%0d troca=%b, want A/0/0", a_out, a_canal, a_troca);
        end
    endtask

    task automatic test_manual();
        for (int i = 0; i < 4; i++) begin
            a_sel = MAN_SEL[i];
            tick();
            vectors++;
            if (a_out !== MAN_OUT[i] || a_canal !== MAN_SEL[i] || a_troca !== 1'b1) begin
                miscompares++;
                $display("FAIL manual step %0d: got out=%h canal=%0d troca=%b, want %h/%0d/1",
                         i, a_out, a_canal, a_troca, MAN_OUT[i], MAN_SEL[i]);
            end
        end
        tick();
        vectors++;
        if (a_out !== 4'hA || a_canal !== 2'd0 || a_troca !== 1'b0) begin
            miscompares++;
            $display("FAIL manual_steady: got out=%h canal=%0d troca=%b, want A/0/0", a_out, a_canal, a_troca);
        end
        a_d = 16'hDCB5;
        tick();
        vectors++;
        if (a_out !== 4'h5 || a_canal !== 2'd0 || a_troca !== 1'b0) begin
            miscompares++;
            $display("FAIL manual_dchange: got out=%h canal=%0d troca=%b, want 5/0/0", a_out, a_canal, a_troca);
        end
        a_d = 16'hDCBA;
    endtask

    task automatic test_scan();
        a_modo = 1'b1;
        a_rst  = 1'b1;
        #1;
        vectors++;
        if (a_out !== 4'h0 || a_canal !== 2'd0 || a_troca !== 1'b0) begin
            miscompares++;
            $display("FAIL scan_async_reset: got out=%h canal=%0d troca=%b, want 0/0/0", a_out, a_canal, a_troca);
        end
        #2;
        a_rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            vectors++;
            if (a_canal !== SCAN_CH[i] || a_out !== SCAN_OUT[i] || a_troca !== SCAN_TR[i]) begin
                miscompares++;
                $display("FAIL scan edge %0d: got canal=%0d out=%h troca=%b, want %0d/%h/%b",
                         i, a_canal, a_out, a_troca, SCAN_CH[i], SCAN_OUT[i], SCAN_TR[i]);
            end
        end
    endtask

    task automatic test_hold();
        tick();
        vectors++;
        if (a_canal !== 2'd0 || a_out !== 4'hA || a_troca !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_pre: got canal=%0d out=%h troca=%b, want 0/A/0", a_canal, a_out, a_troca);
        end
        a_hold = 1'b1;
        a_d    = 16'hDCB7;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (a_canal !== 2'd0 || a_out !== 4'hA || a_troca !== 1'b0) begin
                miscompares++;
                $display("FAIL hold cycle %0d: got canal=%0d out=%h troca=%b, want 0/A/0",
                         i, a_canal, a_out, a_troca);
            end
        end
        a_hold = 1'b0;
        tick();
        vectors++;
        if (a_canal !== 2'd0 || a_out !== 4'h7 || a_troca !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_resume: got canal=%0d out=%h troca=%b, want 0/7/0", a_canal, a_out, a_troca);
        end
        tick();
        vectors++;
        if (a_canal !== 2'd1 || a_out !== 4'hB || a_troca !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_advance: got canal=%0d out=%h troca=%b, want 1/B/1", a_canal, a_out, a_troca);
        end
    endtask

    task automatic test_invalid();
        b_sel = 2'd3;
        tick();
        vectors++;
        if (b_out !== 4'hF || b_canal !== 2'd3 || b_troca !== 1'b1) begin
            miscompares++;
            $display("FAIL invalid_sel: got out=%h canal=%0d troca=%b, want F/3/1", b_out, b_canal, b_troca);
        end
        tick();
        vectors++;
        if (b_out !== 4'hF || b_canal !== 2'd3 || b_troca !== 1'b0) begin
            miscompares++;
            $display("FAIL invalid_steady: got out=%h canal=%0d troca=%b, want F/3/0", b_out, b_canal, b_troca);
        end
        b_modo = 1'b1;
        tick();
        vectors++;
        if (b_out !== 4'hA || b_canal !== 2'd0 || b_troca !== 1'b1) begin
            miscompares++;
            $display("FAIL invalid_to_scan: got out=%h canal=%0d troca=%b, want A/0/1", b_out, b_canal, b_troca);
        end
        tick();
        vectors++;
        if (b_out !== 4'hA || b_canal !== 2'd0 || b_troca !== 1'b0) begin
            miscompares++;
            $display("FAIL invalid_dwell: got out=%h canal=%0d troca=%b, want A/0/0", b_out, b_canal, b_troca);
        end
        tick();
        vectors++;
        if (b_out !== 4'hB || b_canal !== 2'd1 || b_troca !== 1'b1) begin
            miscompares++;
            $display("FAIL invalid_advance: got out=%h canal=%0d troca=%b, want B/1/1", b_out, b_canal, b_troca);
        end
    endtask

    task automatic test_dwell1();
        c_modo = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if (c_canal !== FAST_CH[i] || c_out !== FAST_OUT[i] || c_troca !== 1'b1) begin
                miscompares++;
                $display("FAIL dwell1 edge %0d: got canal=%0d out=%h troca=%b, want %0d/%h/1",
                         i, c_canal, c_out, c_troca, FAST_CH[i], FAST_OUT[i]);
            end
        end
        #2;
        c_rst = 1'b1;
        #1;
        vectors++;
        if (c_out !== 4'h0 || c_canal !== 2'd0 || c_troca !== 1'b0) begin
            miscompares++;
            $display("FAIL dwell1_async_reset: got out=%h canal=%0d troca=%b, want 0/0/0", c_out, c_canal, c_troca);
        end
        @(negedge clk);
        c_rst = 1'b0;
        #1;
        vectors++;
        if (c_canal !== 2'd0 || c_out !== 4'h0) begin
            miscompares++;
            $display("FAIL dwell1_released: got canal=%0d out=%h, want 0/0", c_canal, c_out);
        end
        tick();
        vectors++;
        if (c_canal !== 2'd1 || c_out !== 4'h2 || c_troca !== 1'b1) begin
            miscompares++;
            $display("FAIL dwell1_restart1: got canal=%0d out=%h troca=%b, want 1/2/1", c_canal, c_out, c_troca);
        end
        tick();
        vectors++;
        if (c_canal !== 2'd2 || c_out !== 4'h3 || c_troca !== 1'b1) begin
            miscompares++;
            $display("FAIL dwell1_restart2: got canal=%0d out=%h troca=%b, want 2/3/1", c_canal, c_out, c_troca);
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_scan();
        test_hold();
        test_invalid();
        test_dwell1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
